button_debounce: RTL



---
 rtl/btn_pkg.sv | 25 ++
 rtl/btn_channel.sv | 121 ++++++++++++
 rtl/button_debounce.sv | 102 ++++++++++
 3 files changed

// File: rtl/btn_pkg.sv
// Shared types and sizes for the iCEBreaker button debouncer.
// Holds the per-channel FSM encoding and the press-count helper.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } btn_state_t;

  localparam int NUM_BTN     = 3;
  localparam int PRESS_CNT_W = 8;
  localparam int POP_W       = $clog2(NUM_BTN + 1);

  function automatic logic [POP_W-1:0] popcount(input logic [NUM_BTN-1:0] v);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      n = n + POP_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/btn_channel.sv
// One button: 2-flop synchronizer, debounce FSM and (with BTN_LONGPRESS_EN) a long-press timer.
// Event outputs are combinational "happens on the next edge" strobes; the top registers them.
module btn_channel
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000
`ifdef BTN_LONGPRESS_EN
  ,
  parameter int LONG_CYCLES = 12000000
`endif
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic btn,
  output logic press_evt,
  output logic release_evt,
  output logic long_evt,
  output logic held_nxt
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             s1;
  logic             s2;
  btn_state_t       state_q;
  btn_state_t       state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      s1      <= btn;
      s2      <= s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Any level change seen at s2 before the counter expires falls back without an event.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    press_evt   = 1'b0;
    release_evt = 1'b0;
    case (state_q)
      IDLE: begin
        if (s2) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!s2) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_MAX) begin
          state_d   = HELD;
          press_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!s2) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (s2) begin
          state_d = HELD;
        end else if (cnt_q == CNT_MAX) begin
          state_d     = IDLE;
          release_evt = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign held_nxt = (state_d == HELD) || (state_d == RELEASE_WAIT);

`ifdef BTN_LONGPRESS_EN
  localparam int LONG_W = $clog2(LONG_CYCLES);
  localparam logic [LONG_W-1:0] LONG_MAX = LONG_W'(LONG_CYCLES - 1);

  logic [LONG_W-1:0] lcnt_q;
  logic              long_done_q;

  // Counts only HELD cycles; a release bounce parks it in RELEASE_WAIT without clearing.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
    end else if (press_evt) begin
      lcnt_q      <= '0;
      long_done_q <= 1'b0;
    end else if ((state_q == HELD) && !long_done_q) begin
      if (lcnt_q == LONG_MAX) begin
        long_done_q <= 1'b1;
      end else begin
        lcnt_q <= lcnt_q + 1'b1;
      end
    end
  end

  assign long_evt = (state_q == HELD) && !long_done_q && (lcnt_q == LONG_MAX);
`else
  assign long_evt = 1'b0;
`endif

endmodule

// File: rtl/button_debounce.sv
// Debounces BTN1..BTN3 into press/release pulses, LED toggles and a press count.
// Optional long-press detection is enabled by defining BTN_LONGPRESS_EN.
module button_debounce
  import btn_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 240000,
  parameter int LONG_CYCLES     = 12000000
) (
  input  logic                   CLK,
  input  logic                   RST_N,
  input  logic                   BTN1,
  input  logic                   BTN2,
  input  logic                   BTN3,
  output logic                   LED1,
  output logic                   LED2,
  output logic                   LED3,
  output logic                   LED4,
  output logic [NUM_BTN-1:0]     PRESS,
  output logic [NUM_BTN-1:0]     RELEASE,
  output logic [NUM_BTN-1:0]     LONG,
  output logic [PRESS_CNT_W-1:0] PRESS_CNT,
  output logic                   P1A7,
  output logic                   P1A8,
  output logic                   P1A9,
  output logic                   P1A10
);

  if (DEBOUNCE_CYCLES < 2 || LONG_CYCLES < 2) begin : g_bad_cfg
    $error("button_debounce: DEBOUNCE_CYCLES and LONG_CYCLES must be >= 2");
  end

  logic [NUM_BTN-1:0]     btn;
  logic [NUM_BTN-1:0]     press_evt;
  logic [NUM_BTN-1:0]     release_evt;
  logic [NUM_BTN-1:0]     long_evt;
  logic [NUM_BTN-1:0]     held_nxt;
  logic [NUM_BTN-1:0]     led_q;
  logic [NUM_BTN-1:0]     led_d;
  logic                   led4_q;
  logic [PRESS_CNT_W-1:0] cnt_q;

  assign btn = {BTN3, BTN2, BTN1};

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BTN_LONGPRESS_EN
      ,
      .LONG_CYCLES(LONG_CYCLES)
`endif
    ) u_ch (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .btn        (btn[i]),
      .press_evt  (press_evt[i]),
      .release_evt(release_evt[i]),
      .long_evt   (long_evt[i]),
      .held_nxt   (held_nxt[i])
    );
  end

  // A long press wins over the toggle; both cannot fire on one channel in the same cycle anyway.
  always_comb begin
    led_d = led_q;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (long_evt[i]) begin
        led_d[i] = 1'b0;
      end else if (press_evt[i]) begin
        led_d[i] = ~led_q[i];
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PRESS   <= '0;
      RELEASE <= '0;
      LONG    <= '0;
      led_q   <= '0;
      led4_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      PRESS   <= press_evt;
      RELEASE <= release_evt;
      LONG    <= long_evt;
      led_q   <= led_d;
      led4_q  <= |held_nxt;
      cnt_q   <= cnt_q + PRESS_CNT_W'(popcount(press_evt));
    end
  end

  assign LED1      = led_q[0];
  assign LED2      = led_q[1];
  assign LED3      = led_q[2];
  assign LED4      = led4_q;
  assign PRESS_CNT = cnt_q;
  assign P1A7      = PRESS[0];
  assign P1A8      = PRESS[1];
  assign P1A9      = PRESS[2];
  assign P1A10     = led4_q;

endmodule
